// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory image loader
//
// Receives a big-endian byte stream with a 4-byte word count, that many
// 4-byte program words and a 4-byte XOR checksum. Each word is written to
// instruction memory as it completes. The processor is held until the image
// has been loaded and its checksum matches.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          synchronous active-high reset
//   i_start          one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   i_rx_data        incoming byte
//   i_rx_valid       i_rx_data is valid
//   o_rx_ready       loader accepts a byte this cycle
//   o_mem_addr       instruction-memory byte address
//   o_mem_wdata      word to write
//   o_mem_we         write strobe, one cycle per word
//   o_cpu_hold       stall/reset request to processor
//   o_done           image loaded and checksum OK
//   o_error          oversize count or checksum mismatch
//   o_words_loaded   words written so far
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic [31:0]         o_mem_addr,
  output logic [31:0]         o_mem_wdata,
  output logic                o_mem_we,
  output logic                o_cpu_hold,
  output logic                o_done,
  output logic                o_error,
  output logic [ADDR_WIDTH:0] o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [32:0]         MAX_WORDS = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WL_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  logic [23:0]         r_shift;
  logic [1:0]          r_byte_cnt;
  logic [ADDR_WIDTH:0] r_count;
  logic [ADDR_WIDTH:0] r_words_loaded;
  logic [31:0]         r_csum;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_mem_we;

  logic                w_rx_ready;
  logic                w_accept;
  logic                w_last_byte;
  logic [31:0]         w_word;
  logic [ADDR_WIDTH:0] w_wl_next;
  logic                w_last_word;
  logic                w_oversize;
  logic                w_start_load;

  assign w_rx_ready   = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CSUM);
  assign w_accept     = i_rx_valid && w_rx_ready;
  assign w_last_byte  = (r_byte_cnt == 2'd3);
  // Word completed by the byte being accepted right now.
  assign w_word       = {r_shift, i_rx_data};
  assign w_wl_next    = r_words_loaded + WL_ONE;
  assign w_last_word  = (w_wl_next == r_count);
  assign w_oversize   = ({1'b0, w_word} > MAX_WORDS);
  // start is honoured only when no load is in progress.
  assign w_start_load = i_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_done     = 1'b0;
    o_error    = 1'b0;
    o_cpu_hold = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start_load) w_next = S_HDR;
      end
      S_HDR: begin
        if (w_accept && w_last_byte) begin
          if (w_word == 32'd0)  w_next = S_CSUM;
          else if (w_oversize)  w_next = S_ERR;
          else                  w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_byte && w_last_word) w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept && w_last_byte) begin
          w_next = (w_word == r_csum) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        o_done     = 1'b1;
        o_cpu_hold = 1'b0;
        if (w_start_load) w_next = S_HDR;
      end
      S_ERR: begin
        o_error = 1'b1;
        if (w_start_load) w_next = S_HDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift        <= '0;
      r_byte_cnt     <= '0;
      r_count        <= '0;
      r_words_loaded <= '0;
      r_csum         <= '0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_wdata    <= '0;
      r_mem_we       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_load) begin
        r_shift        <= '0;
        r_byte_cnt     <= '0;
        r_words_loaded <= '0;
        r_csum         <= '0;
      end else if (w_accept) begin
        r_shift    <= {r_shift[15:0], i_rx_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_last_byte) begin
          if (r_state == S_HDR) begin
            r_count <= w_word[ADDR_WIDTH:0];
          end else if ((r_state == S_LOAD) && (r_words_loaded != r_count)) begin
            // Write strobe, address, data and the count all become visible
            // together in the cycle after the word's final byte.
            r_mem_we       <= 1'b1;
            r_mem_wdata    <= w_word;
            r_mem_addr     <= BASE_ADDR + (32'(r_words_loaded) << 2);
            r_words_loaded <= w_wl_next;
            r_csum         <= r_csum ^ w_word;
          end
        end
      end
    end
  end

  assign o_rx_ready     = w_rx_ready;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_we       = r_mem_we;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int AW = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [AW:0] words_loaded;

  int checks = 0;
  int errors = 0;

  int          n_writes;
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  logic [31:0] last_addr;
  logic [31:0] last_data;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_we       (mem_we),
    .o_cpu_hold     (cpu_hold),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with mem_we high is one write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (n_writes < 4) begin
        wr_addr[n_writes] = mem_addr;
        wr_data[n_writes] = mem_wdata;
      end
      last_addr = mem_addr;
      last_data = mem_wdata;
      n_writes  = n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rx_ready === 1'b1) ok = 1;
      else n++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept_timeout observed=rx_ready_low expected=rx_ready_high");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    n_writes = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    settle();
    check("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Two-word load.
    n_writes = 0;
    pulse_start();
    check("s1_hold_after_start", 32'(cpu_hold), 32'd1);
    send_word(32'h0000_0002, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h8C09_0004, 0);
    send_word(32'hAC01_0001, 0);
    settle();
    check("s1_writes", 32'(n_writes), 32'd2);
    check("s1_addr0", wr_addr[0], 32'h0);
    check("s1_data0", wr_data[0], 32'h2008_0005);
    check("s1_addr1", wr_addr[1], 32'h4);
    check("s1_data1", wr_data[1], 32'h8C09_0004);
    check("s1_done", 32'(done), 32'd1);
    check("s1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("s1_words", 32'(words_loaded), 32'd2);
    check("s1_rx_ready", 32'(rx_ready), 32'd0);

    // Bad checksum, started from DONE.
    n_writes = 0;
    pulse_start();
    check("s2_hold_after_start", 32'(cpu_hold), 32'd1);
    check("s2_done_cleared", 32'(done), 32'd0);
    send_word(32'h0000_0002, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h8C09_0004, 0);
    send_word(32'h0000_0000, 0);
    settle();
    check("s2_writes", 32'(n_writes), 32'd2);
    check("s2_error", 32'(error), 32'd1);
    check("s2_cpu_hold", 32'(cpu_hold), 32'd1);
    check("s2_done", 32'(done), 32'd0);
    check("s2_rx_ready", 32'(rx_ready), 32'd0);

    // Oversize header, started from ERR.
    n_writes = 0;
    pulse_start();
    check("s3_error_cleared", 32'(error), 32'd0);
    send_word(32'h0000_0401, 0);
    settle();
    check("s3_error", 32'(error), 32'd1);
    check("s3_writes", 32'(n_writes), 32'd0);
    check("s3_rx_ready", 32'(rx_ready), 32'd0);

    // Zero count with good checksum.
    n_writes = 0;
    pulse_start();
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    settle();
    check("s4_done", 32'(done), 32'd1);
    check("s4_writes", 32'(n_writes), 32'd0);
    check("s4_words", 32'(words_loaded), 32'd0);

    // Zero count with bad checksum.
    pulse_start();
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0001, 0);
    settle();
    check("s4b_error", 32'(error), 32'd1);
    check("s4b_done", 32'(done), 32'd0);

    // Full memory: word i = i; XOR of 0..1023 is zero.
    n_writes = 0;
    pulse_start();
    send_word(32'h0000_0400, 0);
    for (int i = 0; i < 1024; i++) send_word(32'(i), 0);
    send_word(32'h0000_0000, 0);
    settle();
    check("s5_writes", 32'(n_writes), 32'd1024);
    check("s5_last_addr", last_addr, 32'h0000_0FFC);
    check("s5_last_data", last_data, 32'h0000_03FF);
    check("s5_words", 32'(words_loaded), 32'd1024);
    check("s5_done", 32'(done), 32'd1);

    // Gapped valid, plus a start pulse mid-load that must be ignored.
    n_writes = 0;
    pulse_start();
    send_word(32'h0000_0002, 1);
    send_word(32'h2008_0005, 1);
    pulse_start();
    send_word(32'h8C09_0004, 1);
    send_word(32'hAC01_0001, 1);
    settle();
    check("s6_writes", 32'(n_writes), 32'd2);
    check("s6_addr0", wr_addr[0], 32'h0);
    check("s6_data0", wr_data[0], 32'h2008_0005);
    check("s6_addr1", wr_addr[1], 32'h4);
    check("s6_data1", wr_data[1], 32'h8C09_0004);
    check("s6_done", 32'(done), 32'd1);
    check("s6_words", 32'(words_loaded), 32'd2);

    // Reload one zero word from DONE.
    n_writes = 0;
    pulse_start();
    check("s7_hold_after_start", 32'(cpu_hold), 32'd1);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0000, 0);
    check("s7_hold_during_load", 32'(cpu_hold), 32'd1);
    send_word(32'h0000_0000, 0);
    settle();
    check("s7_writes", 32'(n_writes), 32'd1);
    check("s7_addr0", wr_addr[0], 32'h0);
    check("s7_data0", wr_data[0], 32'h0);
    check("s7_done", 32'(done), 32'd1);
    check("s7_words", 32'(words_loaded), 32'd1);

    // Reset after 6 bytes: partial word discarded.
    n_writes = 0;
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("s8_cpu_hold", 32'(cpu_hold), 32'd1);
    check("s8_rx_ready", 32'(rx_ready), 32'd0);
    check("s8_mem_we", 32'(mem_we), 32'd0);
    check("s8_words", 32'(words_loaded), 32'd0);
    check("s8_done", 32'(done), 32'd0);
    settle();
    check("s8_writes", 32'(n_writes), 32'd0);
    check("s8_idle_rx_ready", 32'(rx_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
